framebuffer_fill_writer: RTL and testbench



---
 rtl/framebuffer_fill_writer.sv | 166 ++++++++++++++++
 tb/tb_framebuffer_fill_writer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_fill_writer.sv
// Rectangle-fill write engine for the 320x240 8-bit frame RAM that the VGA path reads.
// It takes one command at a time, clips it to the frame, and writes pixels in raster order while wr_allow is high.
module framebuffer_fill_writer #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [8:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [8:0]        cmd_w,
  input  logic [7:0]        cmd_h,
  input  logic [DATA_W-1:0] cmd_color,
  input  logic              wr_allow,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  localparam logic [9:0]        H_RES_10 = 10'(H_RES);
  localparam logic [9:0]        V_RES_10 = 10'(V_RES);
  localparam logic [ADDR_W-1:0] H_RES_A  = ADDR_W'(H_RES);

  state_t              state_q, state_d;
  logic [8:0]          x_q, x_d, w_q, w_d;
  logic [7:0]          y_q, y_d, h_q, h_d;
  logic [DATA_W-1:0]   color_q, color_d;
  logic [9:0]          x_end_q, x_end_d, y_end_q, y_end_d;
  logic [9:0]          col_q, col_d, row_q, row_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                fb_we_q, fb_we_d;
  logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
  logic [DATA_W-1:0]   fb_data_q, fb_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [9:0]          x_sum, y_sum;
  logic                rect_empty;

  // Ten-bit sums so x+w and y+h can never wrap before clipping.
  assign x_sum = {1'b0, x_q} + {1'b0, w_q};
  assign y_sum = {2'b00, y_q} + {2'b00, h_q};
  assign rect_empty = (w_q == 9'd0) || (h_q == 8'd0) ||
                      ({1'b0, x_q} >= H_RES_10) || ({2'b00, y_q} >= V_RES_10);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    fb_we_d    = 1'b0;
    fb_addr_d  = fb_addr_q;
    fb_data_d  = fb_data_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          x_d     = cmd_x;
          y_d     = cmd_y;
          w_d     = cmd_w;
          h_d     = cmd_h;
          color_d = cmd_color;
          state_d = SETUP;
        end
      end
      SETUP: begin
        x_end_d    = (x_sum > H_RES_10) ? H_RES_10 : x_sum;
        y_end_d    = (y_sum > V_RES_10) ? V_RES_10 : y_sum;
        col_d      = {1'b0, x_q};
        row_d      = {2'b00, y_q};
        row_base_d = ADDR_W'(y_q) * H_RES_A;
        state_d    = rect_empty ? DONE : FILL;
      end
      FILL: begin
        if (wr_allow) begin
          fb_we_d   = 1'b1;
          fb_addr_d = row_base_q + ADDR_W'(col_q);
          fb_data_d = color_q;
          // Row wrap steps the base by one line so no multiply is needed here.
          if (col_q == x_end_q - 10'd1) begin
            col_d      = {1'b0, x_q};
            row_d      = row_q + 10'd1;
            row_base_d = row_base_q + H_RES_A;
            if (row_q == y_end_q - 10'd1) begin
              state_d = DONE;
            end
          end else begin
            col_d = col_q + 10'd1;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      w_q         <= '0;
      h_q         <= '0;
      color_q     <= '0;
      x_end_q     <= '0;
      y_end_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      row_base_q  <= '0;
      cmd_ready_q <= 1'b1;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      w_q         <= w_d;
      h_q         <= h_d;
      color_q     <= color_d;
      x_end_q     <= x_end_d;
      y_end_q     <= y_end_d;
      col_q       <= col_d;
      row_q       <= row_d;
      row_base_q  <= row_base_d;
      cmd_ready_q <= cmd_ready_d;
      fb_we_q     <= fb_we_d;
      fb_addr_q   <= fb_addr_d;
      fb_data_q   <= fb_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign fb_we     = fb_we_q;
  assign fb_addr   = fb_addr_q;
  assign fb_data   = fb_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_framebuffer_fill_writer.sv
// Randomised bench for framebuffer_fill_writer: a pixel-list model of each clipped rectangle
// predicts every write, the busy/ready/done timing and stall behaviour cycle by cycle.
module tb_framebuffer_fill_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [8:0] cmd_x = '0;
  logic [7:0] cmd_y = '0;
  logic [8:0] cmd_w = '0;
  logic [7:0] cmd_h = '0;
  logic [7:0] cmd_color = '0;
  logic       wr_allow = 1'b1;
  logic       fb_we;
  logic [16:0] fb_addr;
  logic [7:0] fb_data;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;
  bit chained = 1'b0;
  int exp_q[$];
  int stall_pat[7] = '{1, 0, 0, 1, 1, 0, 1};

  framebuffer_fill_writer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .wr_allow(wr_allow), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .done(done)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected pixel addresses of the clipped rectangle, in raster order.
  function automatic void build_model(input int x, input int y, input int w, input int h);
    int xe, ye;
    exp_q.delete();
    xe = (x + w < 320) ? x + w : 320;
    ye = (y + h < 240) ? y + h : 240;
    for (int r = y; r < ye; r++)
      for (int c = x; c < xe; c++)
        exp_q.push_back(r * 320 + c);
  endfunction

  task automatic drive_fields(input int x, input int y, input int w, input int h, input int c);
    cmd_x = 9'(x); cmd_y = 8'(y); cmd_w = 9'(w); cmd_h = 8'(h); cmd_color = 8'(c);
    cmd_valid = 1'b1;
  endtask

  task automatic run_cmd(input int x, input int y, input int w, input int h, input int c,
                         input int pct, input bit use_pat, input bit junk, input bit chain,
                         input int nx, input int ny, input int nw, input int nh, input int nc);
    int i, done_idx, cnt, a, writes;
    bit prev_allow, finished, exp_we, in_flight;
    build_model(x, y, w, h);
    if (!chained) begin
      cnt = 0;
      while (!cmd_ready && cnt < 100) begin
        @(negedge clk);
        cnt++;
      end
      if (!cmd_ready) check("ready_wait_timeout", 0, 1);
      drive_fields(x, y, w, h, c);
    end
    chained = 1'b0;
    @(posedge clk);
    done_idx = (exp_q.size() == 0) ? 2 : -1;
    prev_allow = 1'b0;
    finished = 1'b0;
    writes = 0;
    i = 0;
    while (!finished && i < 5000) begin
      @(negedge clk);
      exp_we = (i >= 2) && prev_allow && (exp_q.size() > 0);
      check("fb_we", int'(fb_we), int'(exp_we));
      if (fb_we) check("addr_in_frame", int'(fb_addr < 17'd76800), 1);
      if (exp_we) begin
        a = exp_q.pop_front();
        writes++;
        check("fb_addr", int'(fb_addr), a);
        check("fb_data", int'(fb_data), c);
        if (exp_q.size() == 0) done_idx = i + 1;
      end
      in_flight = (done_idx < 0) || (i < done_idx);
      check("busy", int'(busy), int'(in_flight));
      check("cmd_ready", int'(cmd_ready), int'(!in_flight));
      check("done", int'(done), int'(i == done_idx));
      if (i == done_idx) finished = 1'b1;
      if (use_pat) wr_allow = (i >= 1 && i <= 7) ? stall_pat[i-1][0] : 1'b1;
      else         wr_allow = ($urandom_range(99) < pct);
      prev_allow = wr_allow;
      if (finished) begin
        if (chain) begin
          drive_fields(nx, ny, nw, nh, nc);
          chained = 1'b1;
        end else begin
          cmd_valid = 1'b0;
        end
      end else if (junk) begin
        drive_fields($urandom_range(511), $urandom_range(255), $urandom_range(511),
                     $urandom_range(255), $urandom_range(255));
      end else begin
        cmd_valid = 1'b0;
      end
      i++;
    end
    if (!finished) check("done_timeout", 0, 1);
    $display("[TB] cmd x=%0d y=%0d w=%0d h=%0d color=%0h writes=%0d cycles=%0d", x, y, w, h, c, writes, i);
  endtask

  initial begin
    int writes, cyc;
    repeat (3) @(negedge clk);
    check("rst_fb_we", int'(fb_we), 0);
    check("rst_fb_addr", int'(fb_addr), 0);
    check("rst_fb_data", int'(fb_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    rst = 1'b0;
    @(negedge clk);

    run_cmd(0, 0, 2, 2, 8'hA5, 100, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cmd(318, 239, 5, 3, 8'h3C, 100, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cmd(7, 7, 0, 4, 8'h11, 100, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cmd(320, 7, 4, 4, 8'h12, 100, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cmd(7, 240, 4, 4, 8'h13, 100, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cmd(10, 5, 4, 1, 8'h44, 100, 1, 0, 0, 0, 0, 0, 0, 0);
    run_cmd(20, 10, 3, 2, 8'h55, 70, 0, 1, 1, 100, 50, 2, 2, 8'h66);
    run_cmd(100, 50, 2, 2, 8'h66, 70, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a full-frame fill.
    wr_allow = 1'b1;
    drive_fields(0, 0, 320, 240, 8'h77);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    writes = 0;
    cyc = 0;
    while (writes < 100 && cyc < 400) begin
      if (fb_we) begin
        check("pre_rst_addr", int'(fb_addr), writes);
        writes++;
      end
      if (writes < 100) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("pre_rst_writes", writes, 100);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_fb_we", int'(fb_we), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_cmd_ready", int'(cmd_ready), 1);
    rst = 1'b0;
    $display("[TB] mid-fill reset after %0d writes", writes);
    run_cmd(5, 0, 1, 1, 8'h5A, 100, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 30; k++) begin
      run_cmd($urandom_range(340), $urandom_range(250), $urandom_range(24), $urandom_range(12),
              $urandom_range(255), $urandom_range(30, 100), 0, k[0], 0, 0, 0, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
